// File: rtl/atto_pkg.sv
// Shared types and constants for the configuration sequencer and its cells.
package atto_pkg;

  // Sequencer states: idle (outputs tracking) or loading configuration bytes.
  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Order in which a cell's configuration bytes arrive on the stream.
  typedef enum logic [1:0] {
    F_X  = 2'd0,
    F_Y  = 2'd1,
    F_AB = 2'd2,
    F_CX = 2'd3
  } field_t;

  localparam int CFG_BYTES_PER_CELL = 4;

endpackage

// File: rtl/block.sv
// One routing/logic cell of a word.
//   X byte : [2:0] tap of in_x, [3] invert, [6:4] second tap, [7] OR in second tap -> a
//   Y byte : same layout applied to in_y                                          -> b
//   AB byte: [3:0] LUT f(b,a) at index {b,a}; [7:4] LUT g(b,a) at index {b,a}
//   CX byte: [1:0] out_x source (0:a 1:b 2:f 3:g), [3:2] out_y source (0:b 1:a 2:g 3:f),
//            [4] invert out_x, [5] invert out_y, [6] tie out_x low, [7] tie out_y low
// Outputs are combinational from the configuration registers and the buses.
module block (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  input  logic [7:0] cfg_in,
  input  logic       set_x,
  input  logic       set_y,
  input  logic       set_ab,
  input  logic       set_cx,
  output logic       out_x,
  output logic       out_y
);

  logic [7:0] r_cfg_x;
  logic [7:0] r_cfg_y;
  logic [7:0] r_cfg_ab;
  logic [7:0] r_cfg_cx;
  logic       w_a;
  logic       w_b;
  logic       w_f;
  logic       w_g;
  logic [3:0] w_src_x;
  logic [3:0] w_src_y;

  // Configuration registers, each written by its own one-hot strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfg_x  <= '0;
      r_cfg_y  <= '0;
      r_cfg_ab <= '0;
      r_cfg_cx <= '0;
    end else begin
      if (set_x)  r_cfg_x  <= cfg_in;
      if (set_y)  r_cfg_y  <= cfg_in;
      if (set_ab) r_cfg_ab <= cfg_in;
      if (set_cx) r_cfg_cx <= cfg_in;
    end
  end

  // Tap selection, LUT evaluation and output source muxing.
  always_comb begin
    w_a     = (in_x[r_cfg_x[2:0]] ^ r_cfg_x[3]) | (in_x[r_cfg_x[6:4]] & r_cfg_x[7]);
    w_b     = (in_y[r_cfg_y[2:0]] ^ r_cfg_y[3]) | (in_y[r_cfg_y[6:4]] & r_cfg_y[7]);
    w_f     = r_cfg_ab[{1'b0, w_b, w_a}];
    w_g     = r_cfg_ab[{1'b1, w_b, w_a}];
    w_src_x = {w_g, w_f, w_b, w_a};
    w_src_y = {w_f, w_g, w_a, w_b};
    out_x   = ~r_cfg_cx[6] & (w_src_x[r_cfg_cx[1:0]] ^ r_cfg_cx[4]);
    out_y   = ~r_cfg_cx[7] & (w_src_y[r_cfg_cx[3:2]] ^ r_cfg_cx[5]);
  end

endmodule

// File: rtl/cfg_seq.sv
// Configuration sequencer: walks a wrap-around range of cells, steering each
// accepted stream byte to one configuration field of one cell.
module cfg_seq
  import atto_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [AW-1:0]    i_base,
  input  logic [CW-1:0]    i_count,
  input  logic             i_abort,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_set_x,
  output logic [WIDTH-1:0] o_set_y,
  output logic [WIDTH-1:0] o_set_ab,
  output logic [WIDTH-1:0] o_set_cx
);

  state_t        r_state;
  state_t        w_state_nxt;
  field_t        r_field;
  field_t        w_field_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [AW-1:0] w_addr_inc;
  logic [CW-1:0] r_remaining;
  logic [CW-1:0] w_rem_nxt;
  logic [CW-1:0] w_eff_count;
  logic          r_done;
  logic          w_done_nxt;
  logic          w_accept;

  // A count of zero or one beyond the word means "the whole word".
  assign w_eff_count = ((i_count == '0) || (32'(i_count) > WIDTH)) ? CW'(WIDTH) : i_count;
  // Cell address advances with wrap from the last cell back to cell 0.
  assign w_addr_inc  = (32'(r_addr) >= WIDTH - 1) ? '0 : r_addr + 1'b1;

  // State, cursor and done-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_field     <= F_X;
      r_addr      <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_field     <= w_field_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_rem_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state, cursor update and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_field_nxt = r_field;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_remaining;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Abort takes priority over a simultaneous start.
        if (i_start && !i_abort) begin
          w_state_nxt = LOAD;
          w_addr_nxt  = i_base;
          w_rem_nxt   = w_eff_count;
          w_field_nxt = F_X;
        end
      end
      LOAD: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (i_abort) begin
          w_state_nxt = IDLE;
        end else if (i_valid) begin
          w_accept = 1'b1;
          if (r_field == F_CX) begin
            w_field_nxt = F_X;
            w_addr_nxt  = w_addr_inc;
            w_rem_nxt   = r_remaining - 1'b1;
            if (r_remaining == CW'(1)) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_field_nxt = field_t'(r_field + 2'd1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One-hot strobe decode: only the addressed cell's current field fires.
  always_comb begin
    o_set_x  = '0;
    o_set_y  = '0;
    o_set_ab = '0;
    o_set_cx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_accept && (32'(r_addr) == i)) begin
        unique case (r_field)
          F_X:     o_set_x[i]  = 1'b1;
          F_Y:     o_set_y[i]  = 1'b1;
          F_AB:    o_set_ab[i] = 1'b1;
          default: o_set_cx[i] = 1'b1;
        endcase
      end
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/cfg_word.sv
// A word of WIDTH cells with a streaming configuration loader. Outputs are
// frozen while a load is in progress so the word can be reconfigured live.
module cfg_word
  import atto_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  input  logic             cfg_start,
  input  logic [AW-1:0]    cfg_base,
  input  logic [AW:0]      cfg_count,
  input  logic             cfg_abort,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_busy,
  output logic             cfg_done
);

  logic [WIDTH-1:0] w_set_x;
  logic [WIDTH-1:0] w_set_y;
  logic [WIDTH-1:0] w_set_ab;
  logic [WIDTH-1:0] w_set_cx;
  logic [WIDTH-1:0] w_cell_x;
  logic [WIDTH-1:0] w_cell_y;
  logic [WIDTH-1:0] r_out_x_p1;
  logic [WIDTH-1:0] r_out_y_p1;

  cfg_seq #(.WIDTH(WIDTH)) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (cfg_start),
    .i_base   (cfg_base),
    .i_count  (cfg_count),
    .i_abort  (cfg_abort),
    .i_valid  (cfg_valid),
    .o_ready  (cfg_ready),
    .o_busy   (cfg_busy),
    .o_done   (cfg_done),
    .o_set_x  (w_set_x),
    .o_set_y  (w_set_y),
    .o_set_ab (w_set_ab),
    .o_set_cx (w_set_cx)
  );

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    block u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_x   (in_x),
      .in_y   (in_y),
      .cfg_in (cfg_data),
      .set_x  (w_set_x[g]),
      .set_y  (w_set_y[g]),
      .set_ab (w_set_ab[g]),
      .set_cx (w_set_cx[g]),
      .out_x  (w_cell_x[g]),
      .out_y  (w_cell_y[g])
    );
  end

  // Output stage: track the cells while idle, hold the last value during a load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_x_p1 <= '0;
      r_out_y_p1 <= '0;
    end else if (!cfg_busy) begin
      r_out_x_p1 <= w_cell_x;
      r_out_y_p1 <= w_cell_y;
    end
  end

  assign out_x = r_out_x_p1;
  assign out_y = r_out_y_p1;

endmodule

// File: doc/cfg_word.md
# cfg_word

Parametrised word of `block` cells with an on-chip configuration sequencer, replacing hand-strobed per-cell addressing. A byte stream with valid/ready handshake loads the X, Y, AB and CX configuration of a contiguous, wrap-around range of cells. Outputs are frozen at their pre-load value while a load is in progress, so a fabric word can be reconfigured live. Sits between the top-level configuration port and the routing between words.

## Interface
- `WIDTH`, 8, number of cells (bits) in the word; legal 2..16
- `AW`, $clog2(WIDTH), cell address width (derived; not overridden)
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low (rst_n)
- `in_x`  in  8  X routing bus, fanned to every cell
- `in_y`  in  8  Y routing bus, fanned to every cell
- `out_x`  out  WIDTH  registered X outputs, bit i from cell i
- `out_y`  out  WIDTH  registered Y outputs, bit i from cell i
- `cfg_start`  in  1  begin a load (sampled in IDLE only)
- `cfg_base`  in  AW  first cell of the load, captured at start
- `cfg_count`  in  AW+1  cells to load, captured at start; 0 or >WIDTH means WIDTH
- `cfg_abort`  in  1  terminate load
- `cfg_data`  in  8  configuration byte
- `cfg_valid`  in  1  cfg_data valid
- `cfg_ready`  out  1  sequencer accepts a byte this cycle
- `cfg_busy`  out  1  load in progress
- `cfg_done`  out  1  one-cycle pulse: load completed normally

## Operation
- States: IDLE, LOAD.
- IDLE: `cfg_ready`=0, `cfg_busy`=0. `cfg_start`=1 and `cfg_abort`=0 → LOAD; capture addr=`cfg_base`, remaining=effective count, field=X.
- LOAD: `cfg_ready`=1, `cfg_busy`=1. Byte accepted when `cfg_valid & cfg_ready`.
- Field order per cell: X, Y, AB, CX. On acceptance, exactly one strobe `set_<field>` fires to cell `addr`, with `cfg_in`=`cfg_data`; all other cells see no strobe.
- After CX: field→X, addr→addr+1, wrapping WIDTH-1→0; remaining decrements.
- Accepting CX with remaining=1 → IDLE, `cfg_done`=1 the following cycle.
- `cfg_abort`=1 in LOAD → IDLE next cycle, no byte accepted that cycle, no `cfg_done`. Cells already written keep their new config.
- `cfg_start` during LOAD is ignored. `cfg_start` and `cfg_abort` both high in IDLE: abort wins, remains IDLE.
- Output freeze: `out_x`/`out_y` register cell outputs every cycle in IDLE. They hold in LOAD and resume sampling on the first IDLE cycle.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE, addr/field/remaining 0. `out_x`=0, `out_y`=0, `cfg_ready`=0, `cfg_busy`=0, `cfg_done`=0.
- Cell configuration registers reset through `block`'s own `rst_n`.
- Reset mid-load aborts with no `cfg_done`.
- Start → `cfg_ready` high the next cycle; one byte per cycle max; full load takes 4·count accepting cycles.
- Strobes are combinational from state/addr/field/`cfg_valid`. The cell register updates at the accepting edge.
- Output latency in IDLE: one register stage after cell output.
- After the last byte: IDLE on cycle N+1 with `cfg_done`=1 in that cycle. `out_x`/`out_y` reflect new config from cycle N+2, plus cell latency.

## Structure
- Shared package `atto_pkg`:
  - state enum {IDLE, LOAD}
  - field enum {F_X, F_Y, F_AB, F_CX}
  - constant `CFG_BYTES_PER_CELL`=4
- Sub-module `cfg_seq`: FSM, counters, handshake, and one-hot strobe decode `set_x/y/ab/cx[WIDTH-1:0]`.
- `cfg_word` instantiates `cfg_seq`, a generate loop of WIDTH `block` instances, and the output freeze registers.

## Test plan
- Reset: hold `rst_n`=0 3 cycles with `cfg_valid`=1 → `out_x`=`out_y`=0, `cfg_ready`=0, no strobes.
- Full load, WIDTH=8: start with base=0, count=0, then 32 back-to-back bytes. Bytes 4i..4i+3 reach cell i in X/Y/AB/CX order. `cfg_done` pulses exactly once, one cycle after byte 32, then outputs track the new config.
- Wrap with stalls: base=6, count=3, `cfg_valid` toggling 1/0 → cells 6, 7, 0 written, 12 bytes accepted, cells 1–5 untouched. `cfg_ready` stays 1 through the stalls.
- Freeze: set `in_x` so outputs are 0x5A, start a load, change `in_x` mid-load → `out_x` holds 0x5A until the first IDLE cycle.
- Abort after 5 bytes (cell base+0 complete, X of cell base+1 written) → IDLE next cycle, no `cfg_done`, 6th byte not accepted, partial config retained.
- Simultaneous events: `cfg_start`+`cfg_abort` in IDLE → stays IDLE. `cfg_start` during LOAD → no effect. `rst_n`=0 at byte 10 → IDLE, no `cfg_done`.
